// File: rtl/bist_pkg.sv
// ============================================================================
// bist_pkg : shared BIST FSM state encoding and default SISR constants
// Revision : 1.0
// ============================================================================
`default_nettype none

package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMPRESS = 2'd1,
        ST_COMPARE  = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [15:0] DEFAULT_POLY = 16'h1021;
    localparam logic [15:0] DEFAULT_SEED = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/sisr_reg.sv
// ============================================================================
// sisr_reg : single-input signature register (Galois-style shift/XOR update)
// Revision : 1.0
// ============================================================================
`default_nettype none

module sisr_reg
    import bist_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic w_fb;

    assign w_fb = q[WIDTH-1] ^ din;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= SEED;
        end else if (load) begin
            q <= seed;
        end else if (shift_en) begin
            q <= {q[WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : '0);
        end
    end

endmodule

`default_nettype wire

// File: rtl/signature_analyzer.sv
// ============================================================================
// signature_analyzer : compresses N_BITS scan responses into a SISR signature
//                      and compares the result against a golden value
// Revision : 1.0
// ============================================================================
`default_nettype none

module signature_analyzer
    import bist_pkg::*;
#(
    parameter int               WIDTH  = 16,
    parameter logic [WIDTH-1:0] POLY   = WIDTH'(DEFAULT_POLY),
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(DEFAULT_SEED),
    parameter int               N_BITS = 112
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             scan_out,
    input  logic             scan_valid,
    input  logic [WIDTH-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    localparam int               CNT_W  = $clog2(N_BITS + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_BITS - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_load;
    logic             w_shift;

    // Start is honoured only when no session is in flight.
    assign w_load  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_shift = scan_valid && (r_state == ST_COMPRESS);

    sisr_reg #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_sisr (
        .clock    (clock),
        .reset    (reset),
        .load     (w_load),
        .seed     (SEED),
        .shift_en (w_shift),
        .din      (scan_out),
        .q        (signature)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_COMPRESS;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                    end
                end
                ST_COMPRESS: begin
                    if (scan_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == C_LAST) begin
                            r_state <= ST_COMPARE;
                        end
                    end
                end
                ST_COMPARE: begin
                    pass    <= (signature == golden);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_signature_analyzer.sv
// ============================================================================
// tb_signature_analyzer : directed checks for signature_analyzer (N_BITS 1 and 5)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_signature_analyzer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start5;
    logic        scan_out, scan_valid;
    logic [15:0] golden;
    logic        busy1, done1, pass1;
    logic        busy5, done5, pass5;
    logic [15:0] sig1, sig5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    signature_analyzer #(.N_BITS(1)) dut1 (
        .clock(clk), .reset(rst), .start(start1), .scan_out(scan_out),
        .scan_valid(scan_valid), .golden(golden), .busy(busy1),
        .done(done1), .pass(pass1), .signature(sig1)
    );

    signature_analyzer #(.N_BITS(5)) dut5 (
        .clock(clk), .reset(rst), .start(start5), .scan_out(scan_out),
        .scan_valid(scan_valid), .golden(golden), .busy(busy5),
        .done(done5), .pass(pass5), .signature(sig5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        scan_out   = b;
        scan_valid = 1'b1;
        step();
        scan_valid = 1'b0;
        scan_out   = 1'b0;
    endtask

    task automatic start_dut5();
        start5 = 1'b1;
        step();
        start5 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start5 = 1'b0;
        scan_out = 1'b0; scan_valid = 1'b0; golden = 16'h0000;
        step(); step();
        check("reset_sig", {16'h0, sig5}, 32'h0);
        check("reset_flags", {29'h0, busy5, done5, pass5}, 32'h0);
        rst = 1'b0;
        step();

        // Test 1: N_BITS=1, single '1' bit
        golden = 16'h1021;
        start1 = 1'b1; step(); start1 = 1'b0;
        check("t1_busy_after_start", {31'h0, busy1}, 32'h1);
        send_bit(1'b1);
        check("t1_sig", {16'h0, sig1}, 32'h1021);
        check("t1_not_done_yet", {31'h0, done1}, 32'h0);
        check("t1_idle_ignores_valid", {16'h0, sig5}, 32'h0);
        step();
        check("t1_done", {30'h0, done1, busy1}, 32'h2);
        check("t1_pass", {31'h0, pass1}, 32'h1);

        // Test 2: N_BITS=5, stream 1,0,0,0,0 -> 0x1231
        golden = 16'h1231;
        start_dut5();
        send_bit(1'b1);
        check("t2_sig_bit1", {16'h0, sig5}, 32'h1021);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        check("t2_sig_bit4", {16'h0, sig5}, 32'h8108);
        send_bit(1'b0);
        check("t2_sig", {16'h0, sig5}, 32'h1231);
        check("t2_compare_cycle", {30'h0, busy5, done5}, 32'h2);
        step();
        check("t2_done_pass", {29'h0, busy5, done5, pass5}, 32'h3);
        send_bit(1'b1); step();
        check("t2_hold_sig", {16'h0, sig5}, 32'h1231);
        check("t2_hold_flags", {29'h0, busy5, done5, pass5}, 32'h3);

        // Test 3: wrong golden
        golden = 16'h1230;
        start_dut5();
        check("t3_restart_clears", {15'h0, done5, sig5}, 32'h0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        step();
        check("t3_done_fail", {30'h0, done5, pass5}, 32'h2);

        // Test 4: 3-cycle gaps between bits
        golden = 16'h1231;
        start_dut5();
        send_bit(1'b1); step(); step(); step();
        check("t4_gap_hold", {16'h0, sig5}, 32'h1021);
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b0); step(); step(); step();
        end
        check("t4_gap_busy", {30'h0, busy5, done5}, 32'h2);
        send_bit(1'b0);
        check("t4_sig", {16'h0, sig5}, 32'h1231);
        check("t4_not_done", {31'h0, done5}, 32'h0);
        step();
        check("t4_done_pass", {30'h0, done5, pass5}, 32'h3);

        // Test 5: asynchronous reset mid-session
        start_dut5();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        check("t5_sig_pre", {16'h0, sig5}, 32'h4084);
        #1 rst = 1'b1;
        #1;
        check("t5_async_reset", {13'h0, busy5, done5, pass5, sig5}, 32'h0);
        step();
        rst = 1'b0;
        send_bit(1'b1); step();
        check("t5_no_autostart", {15'h0, busy5, sig5}, 32'h0);
        start_dut5();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        step();
        check("t5_fresh_pass", {30'h0, done5, pass5}, 32'h3);

        // Test 6: start during COMPRESS ignored, start in DONE restarts
        start_dut5();
        send_bit(1'b1); send_bit(1'b0);
        start5 = 1'b1;
        send_bit(1'b0);
        start5 = 1'b0;
        check("t6_start_ignored", {15'h0, busy5, sig5}, 32'h1_4084);
        send_bit(1'b0); send_bit(1'b0);
        step();
        check("t6_done_pass", {29'h0, busy5, done5, pass5}, 32'h3);
        check("t6_sig", {16'h0, sig5}, 32'h1231);
        start_dut5();
        check("t6_restart", {14'h0, busy5, done5, sig5}, 32'h2_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
